alu_multiplier: RTL and testbench
=================================

Name: alu_multiplier

Overview:
- Multi-cycle iterative 32x32 integer multiplier in the CPU ALU, the arithmetic counterpart of the iterative divider.
- Uses the same opcode/src1/src2/result/busy/done contract, so the execute stage drives and stalls on both units identically.
- Computes the low word, signed high word or unsigned high word of the 64-bit product.
- Caches the last product so a back-to-back request on the same operands completes in one cycle.

Parameters:
- BITS_PER_CYCLE, default 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4. ITER = 32/BITS_PER_CYCLE.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- opcode  in  `ALU_OPCODE_WIDTH  ALU operation; sampled only when idle.
- src1  in  32  multiplicand.
- src2  in  32  multiplier.
- result  out  32  selected product word; holds its value until the next completion.
- busy  out  1  high while iterations are in progress.
- done  out  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (RST_N low, asynchronous): result=0, busy=0, done=0, cache valid=0, all internal accumulators=0. If reset is asserted during an operation, that operation is abandoned with no done pulse.
- Opcodes, defined in opcode.h:
  - ALU_MUL: low 32 bits of the product.
  - ALU_MULH: high 32 bits, signed x signed.
  - ALU_MULHU: high 32 bits, unsigned x unsigned.
- Signedness class: ALU_MUL and ALU_MULH are signed; ALU_MULHU is unsigned.
- Every cycle, done defaults to 0.
- IDLE (busy=0), opcode not a multiply: nothing changes; busy and done stay 0.
- IDLE, multiply opcode, cache hit:
  - Hit condition: valid=1, cached src1/src2 equal the inputs, and either the cached class equals the request class or the opcode is ALU_MUL (the low word is class-independent).
  - Next edge: result is set to the selected word of the cached product, done=1, busy stays 0.
- IDLE, multiply opcode, cache miss:
  - Latch src1, src2, class and the selected word (low or high).
  - Signed class: load the magnitudes |src1| and |src2| and record neg = sign(src1) XOR sign(src2). Unsigned class: neg=0.
  - Clear the 64-bit accumulator; set the iteration counter to 0; set busy=1; set valid=0.
- BUSY:
  - Each edge: accumulator += (mcand << (BITS_PER_CYCLE*cnt)) * mplier[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE]; then cnt += 1.
  - Accumulation is 64-bit unsigned, and the shifted multiplicand is zero-extended to 64 bits.
  - On the edge that performs iteration ITER-1:
    - Form the final product P = neg ? -acc : acc (64-bit two's complement).
    - Store P in the cache and set valid=1.
    - Set result to P[31:0] for ALU_MUL, otherwise P[63:32].
    - busy=0, done=1.
  - opcode, src1 and src2 are ignored while busy.
- Latency: on a miss, the request is accepted at edge k; busy is high from k through k+ITER-1, and done/result appear after edge k+ITER (32 cycles at the default). On a hit, done/result appear after edge k.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned. For example, -2^31 x -2^31 = 2^62 with no overflow path.
- A new request can be accepted on the edge immediately after the done pulse, because busy is already 0 during the done cycle.
- The counter is $clog2(ITER) bits wide. Completion is detected by cnt==ITER-1, not by counter wrap.

Decomposition:
- opcode.h gains ALU_MUL, ALU_MULH and ALU_MULHU alongside the existing ALU opcodes. No other shared constants are needed.
- One natural combinational sub-module, mul_step: inputs acc[63:0], mcand[31:0], the mplier slice and shift amount; output is the next acc. It is instantiated once, and the control and cache logic stay in alu_multiplier.

Test Plan:
- MULHU src1=0xFFFFFFFF, src2=0xFFFFFFFF (BITS=1) -> busy high for 32 cycles, then result=0xFFFFFFFE with done high for exactly 1 cycle. Internal P=0xFFFFFFFE_00000001.
- MUL 0xFFFFFFFF x 0x00000002 -> result=0xFFFFFFFE after 32 cycles. Then MULH with the same operands -> cache hit: result=0xFFFFFFFF after 1 edge, done=1, busy never asserted.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000. Then MULHU with the same operands -> miss (class differs), full 32-cycle recompute, result=0x40000000.
- BITS_PER_CYCLE=4: MUL 7 x 0xFFFFFFFD -> busy for 8 cycles, result=0xFFFFFFEB. MULH on the same operands hits -> 0xFFFFFFFF.
- Reset mid-operation: drop RST_N on the 10th busy cycle -> busy, done and result go to 0 immediately with no done pulse. Repeating the same request after reset -> full 32-cycle miss.
- Non-multiply opcode (e.g. ALU_DIV) while idle -> busy and done stay 0 and result is unchanged. Changing opcode/src1/src2 while busy -> completed result reflects the latched operands.

Source files
------------

// File: rtl/alu_multiplier_pkg.sv
// alu_multiplier_pkg: ALU opcode encodings and multiplier helpers shared by the execute-stage units
package alu_multiplier_pkg;
   localparam int ALU_OPCODE_WIDTH = 5;
   typedef logic [ALU_OPCODE_WIDTH-1:0] opcode_t;
   localparam opcode_t ALU_ADD   = 5'd0;
   localparam opcode_t ALU_DIV   = 5'd8;
   localparam opcode_t ALU_MUL   = 5'd12;
   localparam opcode_t ALU_MULH  = 5'd13;
   localparam opcode_t ALU_MULHU = 5'd14;
   function automatic logic is_mul_op(opcode_t op);
      return op == ALU_MUL || op == ALU_MULH || op == ALU_MULHU;
   endfunction
   function automatic logic is_signed_op(opcode_t op);
      return op != ALU_MULHU;
   endfunction
   // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude
   function automatic logic [31:0] magnitude(logic [31:0] v, logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction
endpackage

// File: rtl/alu_multiplier_if.sv
// alu_multiplier_if: opcode/operand request and result/busy/done status between execute stage and ALU unit
interface alu_multiplier_if;
   import alu_multiplier_pkg::*;
   opcode_t     opcode;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] result;
   logic        busy;
   logic        done;
   modport master (output opcode, src1, src2, input result, busy, done);
   modport slave  (input opcode, src1, src2, output result, busy, done);
endinterface

// File: rtl/alu_multiplier_mul_step.sv
// alu_multiplier_mul_step: one shift-and-add iteration folding a multiplier slice into the 64-bit accumulator
module alu_multiplier_mul_step #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [63:0]               acc,
   input  logic [31:0]               mcand,
   input  logic [BITS_PER_CYCLE-1:0] slice,
   input  logic [4:0]                shamt,
   output logic [63:0]               acc_nxt
);
   logic [63:0] sh;
   assign sh      = {32'b0, mcand} << shamt;
   assign acc_nxt = acc + sh * 64'(slice);
endmodule

// File: rtl/alu_multiplier.sv
// alu_multiplier: iterative 32x32 multiplier returning MUL/MULH/MULHU words with a last-product cache
module alu_multiplier
   import alu_multiplier_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   alu_multiplier_if.slave  bus
);
   localparam int ITER = 32 / BITS_PER_CYCLE;
   localparam int CW   = $clog2(ITER);
   logic          busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic          neg_q, neg_d, hi_q, hi_d, c_sgn_q, c_sgn_d;
   logic [31:0]   result_q, result_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic [31:0]   c_src1_q, c_src1_d, c_src2_q, c_src2_d;
   logic [63:0]   acc_q, acc_d, cache_q, cache_d, acc_nxt, prod;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    shamt;
   logic          req_sgn, hit, last;
   assign req_sgn = is_signed_op(bus.opcode);
   // the low word is identical for signed and unsigned operands, so MUL hits either class
   assign hit     = valid_q && bus.src1 == c_src1_q && bus.src2 == c_src2_q &&
                    (c_sgn_q == req_sgn || bus.opcode == ALU_MUL);
   assign shamt   = 5'(32'(cnt_q) * BITS_PER_CYCLE);
   assign last    = cnt_q == CW'(ITER - 1);
   assign prod    = neg_q ? -acc_nxt : acc_nxt;
   alu_multiplier_mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
      .acc     (acc_q),
      .mcand   (mcand_q),
      .slice   (mplier_q[shamt +: BITS_PER_CYCLE]),
      .shamt   (shamt),
      .acc_nxt (acc_nxt)
   );
   always_comb begin
      busy_d   = busy_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      c_sgn_d  = c_sgn_q;
      result_d = result_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      c_src1_d = c_src1_q;
      c_src2_d = c_src2_q;
      acc_d    = acc_q;
      cache_d  = cache_q;
      cnt_d    = cnt_q;
      if (!busy_q && is_mul_op(bus.opcode)) begin
         if (hit) begin
            result_d = bus.opcode == ALU_MUL ? cache_q[31:0] : cache_q[63:32];
            done_d   = 1'b1;
         end else begin
            c_src1_d = bus.src1;
            c_src2_d = bus.src2;
            c_sgn_d  = req_sgn;
            hi_d     = bus.opcode != ALU_MUL;
            mcand_d  = magnitude(bus.src1, req_sgn);
            mplier_d = magnitude(bus.src2, req_sgn);
            neg_d    = req_sgn && (bus.src1[31] ^ bus.src2[31]);
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
         end
      end else if (busy_q) begin
         acc_d = acc_nxt;
         cnt_d = cnt_q + 1'b1;
         if (last) begin
            cache_d  = prod;
            valid_d  = 1'b1;
            result_d = hi_q ? prod[63:32] : prod[31:0];
            busy_d   = 1'b0;
            done_d   = 1'b1;
         end
      end
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
         c_sgn_q  <= 1'b0;
         result_q <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         c_src1_q <= '0;
         c_src2_q <= '0;
         acc_q    <= '0;
         cache_q  <= '0;
         cnt_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         c_sgn_q  <= c_sgn_d;
         result_q <= result_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         c_src1_q <= c_src1_d;
         c_src2_q <= c_src2_d;
         acc_q    <= acc_d;
         cache_q  <= cache_d;
         cnt_q    <= cnt_d;
      end
   end
   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_multiplier.sv
// tb_alu_multiplier: directed vectors against a 1-bit/cycle and a 4-bit/cycle multiplier instance
module tb_alu_multiplier;
   import alu_multiplier_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   lat;
   logic dn, dn_next;
   logic [31:0] res;
   alu_multiplier_if if1 ();
   alu_multiplier_if if4 ();
   alu_multiplier #(.BITS_PER_CYCLE(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1.slave));
   alu_multiplier #(.BITS_PER_CYCLE(4)) dut4 (.CLK(clk), .RST_N(rst_n), .bus(if4.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // issue one request, scramble inputs while busy, report busy length, done, result and done one cycle later
   task automatic do_op(input bit sel, input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                        output int l, output logic d, output logic [31:0] r, output logic dnx);
      @(negedge clk);
      if (sel) begin if4.opcode = op; if4.src1 = a; if4.src2 = b; end
      else begin if1.opcode = op; if1.src1 = a; if1.src2 = b; end
      @(posedge clk); #1;
      if (sel) begin if4.opcode = ALU_DIV; if4.src1 = ~a; if4.src2 = a ^ b; end
      else begin if1.opcode = ALU_DIV; if1.src1 = ~a; if1.src2 = a ^ b; end
      l = 0;
      while ((sel ? if4.busy : if1.busy) && l < 200) begin
         @(posedge clk); #1;
         l++;
      end
      d = sel ? if4.done : if1.done;
      r = sel ? if4.result : if1.result;
      @(posedge clk); #1;
      dnx = sel ? if4.done : if1.done;
   endtask
   initial begin
      if1.opcode = ALU_ADD; if1.src1 = '0; if1.src2 = '0;
      if4.opcode = ALU_ADD; if4.src1 = '0; if4.src2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", if1.result, 32'h0);
      chk("reset_busy", 32'(if1.busy), 32'h0);
      chk("reset_done", 32'(if1.done), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      do_op(0, ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, dn, res, dn_next);
      chk("mulhu_ff_lat", 32'(lat), 32'd32);
      chk("mulhu_ff_done", 32'(dn), 32'h1);
      chk("mulhu_ff_res", res, 32'hFFFFFFFE);
      chk("mulhu_ff_done_pulse", 32'(dn_next), 32'h0);
      do_op(0, ALU_MUL, 32'hFFFFFFFF, 32'h00000002, lat, dn, res, dn_next);
      chk("mul_m1x2_lat", 32'(lat), 32'd32);
      chk("mul_m1x2_res", res, 32'hFFFFFFFE);
      do_op(0, ALU_MULH, 32'hFFFFFFFF, 32'h00000002, lat, dn, res, dn_next);
      chk("mulh_hit_lat", 32'(lat), 32'd0);
      chk("mulh_hit_done", 32'(dn), 32'h1);
      chk("mulh_hit_res", res, 32'hFFFFFFFF);
      chk("mulh_hit_done_pulse", 32'(dn_next), 32'h0);
      do_op(0, ALU_MULH, 32'h80000000, 32'h80000000, lat, dn, res, dn_next);
      chk("mulh_min_lat", 32'(lat), 32'd32);
      chk("mulh_min_res", res, 32'h40000000);
      do_op(0, ALU_MULHU, 32'h80000000, 32'h80000000, lat, dn, res, dn_next);
      chk("mulhu_class_miss_lat", 32'(lat), 32'd32);
      chk("mulhu_class_miss_res", res, 32'h40000000);
      do_op(0, ALU_MUL, 32'h80000000, 32'h80000000, lat, dn, res, dn_next);
      chk("mul_low_hit_lat", 32'(lat), 32'd0);
      chk("mul_low_hit_res", res, 32'h00000000);
      do_op(0, ALU_DIV, 32'h00000005, 32'h00000007, lat, dn, res, dn_next);
      chk("nonmul_busy", 32'(lat), 32'd0);
      chk("nonmul_done", 32'(dn), 32'h0);
      chk("nonmul_result_held", res, 32'h00000000);
      do_op(1, ALU_MUL, 32'h00000007, 32'hFFFFFFFD, lat, dn, res, dn_next);
      chk("b4_mul_lat", 32'(lat), 32'd8);
      chk("b4_mul_res", res, 32'hFFFFFFEB);
      do_op(1, ALU_MULH, 32'h00000007, 32'hFFFFFFFD, lat, dn, res, dn_next);
      chk("b4_mulh_hit_lat", 32'(lat), 32'd0);
      chk("b4_mulh_hit_res", res, 32'hFFFFFFFF);
      do_op(1, ALU_MULHU, 32'h00000007, 32'hFFFFFFFD, lat, dn, res, dn_next);
      chk("b4_mulhu_lat", 32'(lat), 32'd8);
      chk("b4_mulhu_res", res, 32'h00000006);
      @(negedge clk);
      if1.opcode = ALU_MUL; if1.src1 = 32'h12345678; if1.src2 = 32'h00000003;
      @(posedge clk); #1;
      if1.opcode = ALU_DIV;
      chk("abort_busy_start", 32'(if1.busy), 32'h1);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(if1.busy), 32'h0);
      chk("abort_done", 32'(if1.done), 32'h0);
      chk("abort_result", if1.result, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      do_op(0, ALU_MUL, 32'h12345678, 32'h00000003, lat, dn, res, dn_next);
      chk("after_reset_lat", 32'(lat), 32'd32);
      chk("after_reset_res", res, 32'h369D0368);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
